// File: rtl/cache_ctrl_gen2_if.sv
// cache_ctrl_gen2_if: groups the request, memory-handshake and flush status
// signals of cache_ctrl_gen2.
//   master : requester / cache datapath / memory side (drives requests and done_mem)
//   slave  : the controller (drives memory request, status and pulses)
interface cache_ctrl_gen2_if #(
    parameter int unsigned IDX_W = 4
);
    logic             flush;
    logic             enable_cache;
    logic             hit;
    logic             victim_dirty;
    logic             line_dirty;
    logic             done_mem;
    logic             mem_enable;
    logic             mem_wr;
    logic             mem_rdy;
    logic             idle;
    logic [IDX_W-1:0] flush_idx;
    logic             one_line_flushed;
    logic             flush_finish;
    logic             mem_err;

    modport master (
        output flush, enable_cache, hit, victim_dirty, line_dirty, done_mem,
        input  mem_enable, mem_wr, mem_rdy, idle, flush_idx,
               one_line_flushed, flush_finish, mem_err
    );

    modport slave (
        input  flush, enable_cache, hit, victim_dirty, line_dirty, done_mem,
        output mem_enable, mem_wr, mem_rdy, idle, flush_idx,
               one_line_flushed, flush_finish, mem_err
    );
endinterface

// File: rtl/cache_ctrl_gen2.sv
// cache_ctrl_gen2: cache controller FSM sequencing hit, dirty-victim
// writeback-then-refill, and full-cache flush between the cache datapath and
// the main-memory port.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - cache_ctrl_gen2_if.slave:
//          in : flush, enable_cache, hit, victim_dirty, line_dirty, done_mem
//          out: mem_enable, mem_wr (Moore), idle (Moore), flush_idx (registered),
//               mem_rdy, one_line_flushed, flush_finish, mem_err (Mealy pulses)
//
// Optional feature: define CACHE_CTRL_TIMEOUT_EN to enable the memory-timeout
// watchdog (abort after MEM_TIMEOUT cycles in a memory-wait state without
// done_mem). Without it mem_err is tied low and the FSM waits indefinitely.
module cache_ctrl_gen2 #(
    parameter int unsigned NUM_LINES   = 16,
    parameter int unsigned IDX_W       = $clog2(NUM_LINES),
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    cache_ctrl_gen2_if.slave bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);

    // Reject illegal parameterisations at elaboration time.
    if (NUM_LINES < 2 || (NUM_LINES & (NUM_LINES - 1)) != 0 ||
        (1 << IDX_W) != NUM_LINES || MEM_TIMEOUT == 0) begin : g_param_check
        $error("cache_ctrl_gen2: illegal NUM_LINES/IDX_W/MEM_TIMEOUT");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_HIT,
        S_EVICT,
        S_REFILL,
        S_FLUSH_CHK,
        S_FLUSH_WR
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic mem_enable_c;
    logic mem_wr_c;
    logic idle_c;
    logic mem_rdy_c;
    logic line_done_c;
    logic flush_finish_c;
    logic mem_err_c;

`ifdef CACHE_CTRL_TIMEOUT_EN
    localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wait_c;
    logic             timeout_c;
`endif

    // State, flush index and watchdog registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
`ifdef CACHE_CTRL_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
`ifdef CACHE_CTRL_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Next-state, flush index and output decode.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        mem_enable_c   = 1'b0;
        mem_wr_c       = 1'b0;
        idle_c         = 1'b0;
        mem_rdy_c      = 1'b0;
        line_done_c    = 1'b0;
        flush_finish_c = 1'b0;
        mem_err_c      = 1'b0;
`ifdef CACHE_CTRL_TIMEOUT_EN
        cnt_d          = '0;
        wait_c         = 1'b0;
        timeout_c      = 1'b0;
`endif

        unique case (state_q)
            S_IDLE: begin
                idle_c = 1'b1;
                if (bus.flush) begin
                    state_d = S_FLUSH_CHK;
                    idx_d   = '0;
                end else if (bus.enable_cache) begin
                    if (bus.hit)               state_d = S_HIT;
                    else if (bus.victim_dirty) state_d = S_EVICT;
                    else                       state_d = S_REFILL;
                end
            end

            S_HIT: begin
                state_d = S_IDLE;
            end

            S_EVICT: begin
                mem_enable_c = 1'b1;
                mem_wr_c     = 1'b1;
                if (bus.done_mem) state_d = S_REFILL;
            end

            S_REFILL: begin
                mem_enable_c = 1'b1;
                if (bus.done_mem) begin
                    mem_rdy_c = 1'b1;
                    state_d   = S_IDLE;
                end
            end

            S_FLUSH_CHK: begin
                if (bus.line_dirty) begin
                    state_d = S_FLUSH_WR;
                end else begin
                    line_done_c = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        flush_finish_c = 1'b1;
                        idx_d          = '0;
                        state_d        = S_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            S_FLUSH_WR: begin
                mem_enable_c = 1'b1;
                mem_wr_c     = 1'b1;
                if (bus.done_mem) begin
                    line_done_c = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        flush_finish_c = 1'b1;
                        idx_d          = '0;
                        state_d        = S_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_FLUSH_CHK;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase

`ifdef CACHE_CTRL_TIMEOUT_EN
        // Watchdog: counts cycles spent in one memory-wait state; done_mem on
        // the final allowed cycle still completes normally.
        wait_c    = (state_q == S_EVICT) || (state_q == S_REFILL) ||
                    (state_q == S_FLUSH_WR);
        timeout_c = wait_c && !bus.done_mem &&
                    (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
        if (timeout_c) begin
            mem_err_c = 1'b1;
            state_d   = S_IDLE;
            idx_d     = '0;
        end
        // Cleared whenever the state changes, so every wait state starts at 0.
        if (wait_c && (state_d == state_q)) cnt_d = cnt_q + CNT_W'(1);
`endif
    end

    assign bus.mem_enable       = mem_enable_c;
    assign bus.mem_wr           = mem_wr_c;
    assign bus.idle             = idle_c;
    assign bus.flush_idx        = idx_q;
    assign bus.mem_rdy          = mem_rdy_c;
    assign bus.one_line_flushed = line_done_c;
    assign bus.flush_finish     = flush_finish_c;
    assign bus.mem_err          = mem_err_c;

endmodule

// File: tb/tb_cache_ctrl_gen2.sv
// tb_cache_ctrl_gen2: self-checking bench for cache_ctrl_gen2. Operations are
// expanded into per-cycle {inputs, expected outputs} records from their
// transaction-level timing, queued, then applied and compared cycle by cycle.
`timescale 1ns/1ps
module tb_cache_ctrl_gen2;

    localparam int unsigned NUM_LINES   = 16;
    localparam int unsigned IDX_W       = 4;
    localparam int unsigned MEM_TIMEOUT = 8;

    typedef struct packed {
        logic             mem_enable;
        logic             mem_wr;
        logic             mem_rdy;
        logic             idle;
        logic [IDX_W-1:0] idx;
        logic             olf;
        logic             ff;
        logic             err;
    } outs_t;

    typedef struct {
        string name;
        logic  flush;
        logic  enable_cache;
        logic  hit;
        logic  victim_dirty;
        logic  line_dirty;
        logic  done_mem;
        outs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    cache_ctrl_gen2_if #(.IDX_W(IDX_W)) bus ();

    cache_ctrl_gen2 #(
        .NUM_LINES  (NUM_LINES),
        .IDX_W      (IDX_W),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    vec_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic outs_t o_idle();
        outs_t o = '0;
        o.idle = 1'b1;
        return o;
    endfunction

    function automatic void push(input string n, input logic fl, input logic en,
                                 input logic h, input logic vd, input logic ld,
                                 input logic dm, input outs_t e);
        vec_t v;
        v.name = n; v.flush = fl; v.enable_cache = en; v.hit = h;
        v.victim_dirty = vd; v.line_dirty = ld; v.done_mem = dm; v.exp = e;
        q.push_back(v);
    endfunction

    // Idle cycles: no request, done_mem noise must be ignored.
    function automatic void gen_idle(input int n);
        for (int i = 0; i < n; i++)
            push("idle", 1'b0, 1'b0, rb(), rb(), rb(), rb(), o_idle());
    endfunction

    // Hit: request cycle, then exactly one non-idle cycle with no memory activity.
    function automatic void gen_hit();
        push("hit_req", 1'b0, 1'b1, 1'b1, rb(), rb(), rb(), o_idle());
        push("hit", rb(), rb(), rb(), rb(), rb(), rb(), outs_t'('0));
    endfunction

    // Miss: optional writeback of l1 cycles, then refill of l2 cycles.
    function automatic void gen_miss(input logic dirty, input int l1, input int l2);
        outs_t o;
        push("miss_req", 1'b0, 1'b1, 1'b0, dirty, rb(), rb(), o_idle());
        if (dirty) begin
            for (int k = 1; k <= l1; k++) begin
                o = '0; o.mem_enable = 1'b1; o.mem_wr = 1'b1;
                push("evict", rb(), rb(), rb(), rb(), rb(), 1'(k == l1), o);
            end
        end
        for (int k = 1; k <= l2; k++) begin
            o = '0; o.mem_enable = 1'b1; o.mem_rdy = 1'(k == l2);
            push("refill", rb(), rb(), rb(), rb(), rb(), 1'(k == l2), o);
        end
    endfunction

    // Flush: one check cycle per line, plus a write burst for each dirty line.
    function automatic void gen_flush(input logic [NUM_LINES-1:0] mask, input logic with_en);
        outs_t o;
        int    lat;
        logic  last;
        push("flush_req", 1'b1, with_en, rb(), rb(), rb(), rb(), o_idle());
        for (int i = 0; i < int'(NUM_LINES); i++) begin
            last = 1'(i == int'(NUM_LINES) - 1);
            o = '0; o.idx = IDX_W'(i); o.olf = !mask[i]; o.ff = !mask[i] && last;
            push("flush_chk", rb(), rb(), rb(), rb(), mask[i], rb(), o);
            if (mask[i]) begin
                lat = int'($urandom_range(1, 5));
                for (int k = 1; k <= lat; k++) begin
                    o = '0; o.mem_enable = 1'b1; o.mem_wr = 1'b1; o.idx = IDX_W'(i);
                    o.olf = 1'(k == lat); o.ff = 1'(k == lat) && last;
                    push("flush_wr", rb(), rb(), rb(), rb(), rb(), 1'(k == lat), o);
                end
            end
        end
    endfunction

`ifdef CACHE_CTRL_TIMEOUT_EN
    // Refill that never completes: abort on the MEM_TIMEOUT-th wait cycle.
    function automatic void gen_refill_timeout();
        outs_t o;
        push("to_req", 1'b0, 1'b1, 1'b0, 1'b0, rb(), rb(), o_idle());
        for (int k = 1; k <= int'(MEM_TIMEOUT); k++) begin
            o = '0; o.mem_enable = 1'b1; o.err = 1'(k == int'(MEM_TIMEOUT));
            push("to_refill", rb(), rb(), rb(), rb(), rb(), 1'b0, o);
        end
    endfunction

    // Flush write at line `at` that never completes: abort, index returns to 0.
    function automatic void gen_flush_timeout(input int at);
        outs_t o;
        push("to_flush_req", 1'b1, 1'b0, rb(), rb(), rb(), rb(), o_idle());
        for (int i = 0; i <= at; i++) begin
            o = '0; o.idx = IDX_W'(i); o.olf = 1'(i != at);
            push("to_flush_chk", rb(), rb(), rb(), rb(), 1'(i == at), rb(), o);
        end
        for (int k = 1; k <= int'(MEM_TIMEOUT); k++) begin
            o = '0; o.mem_enable = 1'b1; o.mem_wr = 1'b1; o.idx = IDX_W'(at);
            o.err = 1'(k == int'(MEM_TIMEOUT));
            push("to_flush_wr", rb(), rb(), rb(), rb(), rb(), 1'b0, o);
        end
    endfunction
`endif

    function automatic outs_t sample();
        outs_t a;
        a.mem_enable = bus.mem_enable; a.mem_wr = bus.mem_wr;
        a.mem_rdy    = bus.mem_rdy;    a.idle   = bus.idle;
        a.idx        = bus.flush_idx;  a.olf    = bus.one_line_flushed;
        a.ff         = bus.flush_finish; a.err  = bus.mem_err;
        return a;
    endfunction

    task automatic check(input string name, input outs_t act, input outs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got {en,wr,rdy,idle,idx,olf,ff,err}=%b_%b_%b_%b_%h_%b_%b_%b required %b_%b_%b_%b_%h_%b_%b_%b",
                     name, $time, act.mem_enable, act.mem_wr, act.mem_rdy, act.idle, act.idx,
                     act.olf, act.ff, act.err, exp.mem_enable, exp.mem_wr, exp.mem_rdy,
                     exp.idle, exp.idx, exp.olf, exp.ff, exp.err);
        end
    endtask

    // Called just after a rising edge: drive, compare mid-cycle, advance.
    task automatic apply(input vec_t v);
        bus.flush        = v.flush;
        bus.enable_cache = v.enable_cache;
        bus.hit          = v.hit;
        bus.victim_dirty = v.victim_dirty;
        bus.line_dirty   = v.line_dirty;
        bus.done_mem     = v.done_mem;
        @(negedge clk);
        check(v.name, sample(), v.exp);
        @(posedge clk);
        #1;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n && q.size() > 0; i++) apply(q.pop_front());
    endtask

    task automatic drive_quiet();
        bus.flush = 1'b0; bus.enable_cache = 1'b0; bus.hit = 1'b0;
        bus.victim_dirty = 1'b0; bus.line_dirty = 1'b0; bus.done_mem = 1'b0;
    endtask

    initial begin
        outs_t o;
        int    op;

        rst = 1'b0;
        drive_quiet();
        #12;
        check("reset_state", sample(), o_idle());
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors from the test plan.
        gen_idle(2);
        gen_hit();
        gen_idle(1);
        gen_miss(1'b1, 3, 3);
        gen_miss(1'b0, 1, 2);
        gen_miss(1'b1, 1, 1);
        gen_flush(16'h8008, 1'b0);
        gen_flush(16'h0000, 1'b1);
        gen_hit();
        gen_flush(16'hFFFF, 1'b0);
        gen_idle(1);
        for (int i = 0; i < q.size(); i++) apply(q[i]);
        q.delete();

        // Reset during the line-5 flush write.
        gen_flush(16'h0020, 1'b0);
        run_n(7);
        q.delete();
        drive_quiet();
        #1;
        o = '0; o.mem_enable = 1'b1; o.mem_wr = 1'b1; o.idx = IDX_W'(5);
        check("pre_reset_flush_wr", sample(), o);
        rst = 1'b0;
        #1;
        check("async_reset", sample(), o_idle());
        @(negedge clk);
        check("held_reset", sample(), o_idle());
        rst = 1'b1;
        @(posedge clk);
        #1;
        gen_flush(16'h0001, 1'b0);
        run_n(q.size());

`ifdef CACHE_CTRL_TIMEOUT_EN
        gen_refill_timeout();
        gen_idle(1);
        gen_flush_timeout(2);
        gen_idle(1);
        gen_miss(1'b0, 1, int'(MEM_TIMEOUT));
        gen_idle(1);
        run_n(q.size());
`endif

        // Randomised operation mix against the transaction-level model.
        for (int t = 0; t < 80; t++) begin
            op = int'($urandom_range(0, 9));
            case (op)
                0, 1, 2: gen_hit();
                3, 4:    gen_miss(1'b1, int'($urandom_range(1, 6)), int'($urandom_range(1, 6)));
                5, 6:    gen_miss(1'b0, 1, int'($urandom_range(1, 6)));
                7:       gen_flush(NUM_LINES'($urandom), rb());
                default: gen_idle(int'($urandom_range(1, 3)));
            endcase
            run_n(q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
